// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: N producer streams in, one registered stream out, valid/ready on every channel
interface rr_stream_mux_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 16
);
    localparam int SEL_W = $clog2(NUM_CH);
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N:1 stream mux with round-robin or fixed-priority arbitration
module rr_stream_mux #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 16,
    parameter int MODE   = 0
) (
    input logic            clk,
    input logic            rst,
    rr_stream_mux_if.slave s
);
    localparam int SEL_W = $clog2(NUM_CH);
    logic [WIDTH-1:0] ch [NUM_CH];
    logic [SEL_W-1:0] ptr_q, ptr_d, out_sel_q, out_sel_d, gnt_i, idx;
    logic [SEL_W:0]   sum;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, gnt_v, ld, xfer;
    // Walk the search order backwards so the first valid channel in order wins
    always_comb begin
        gnt_v = 1'b0;
        gnt_i = '0;
        sum   = '0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            ch[k] = s.in_data[k*WIDTH +: WIDTH];
            sum   = {1'b0, ptr_q} + (SEL_W+1)'(k);
            idx   = MODE != 0 ? SEL_W'(k)
                  : sum >= (SEL_W+1)'(NUM_CH) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH)) : SEL_W'(sum);
            if (s.in_valid[idx]) begin
                gnt_v = 1'b1;
                gnt_i = idx;
            end
        end
    end
    always_comb begin
        ld          = !out_valid_q || s.out_ready;
        xfer        = !rst && ld && gnt_v;
        s.in_ready  = xfer ? NUM_CH'(1) << gnt_i : '0;
        out_data_d  = xfer ? ch[gnt_i] : out_data_q;
        out_sel_d   = xfer ? gnt_i : out_sel_q;
        out_valid_d = xfer ? 1'b1 : s.out_ready ? 1'b0 : out_valid_q;
        ptr_d       = !(xfer && MODE == 0) ? ptr_q
                    : gnt_i == SEL_W'(NUM_CH - 1) ? '0 : gnt_i + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign s.out_data  = out_data_q;
    assign s.out_sel   = out_sel_q;
    assign s.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: vector table, corner sequences and per-instance scoreboard models
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    rr_stream_mux_if #(.WIDTH(4),  .NUM_CH(16)) i0 ();
    rr_stream_mux_if #(.WIDTH(4),  .NUM_CH(16)) i1 ();
    rr_stream_mux_if #(.WIDTH(32), .NUM_CH(5))  i2 ();
    rr_stream_mux #(.WIDTH(4),  .NUM_CH(16), .MODE(0)) d0 (.clk(clk), .rst(rst), .s(i0.slave));
    rr_stream_mux #(.WIDTH(4),  .NUM_CH(16), .MODE(1)) d1 (.clk(clk), .rst(rst), .s(i1.slave));
    rr_stream_mux #(.WIDTH(32), .NUM_CH(5),  .MODE(0)) d2 (.clk(clk), .rst(rst), .s(i2.slave));
    typedef struct {int sel; logic [31:0] data;} beat_t;
    typedef struct {logic [15:0] v; logic rdy; logic [15:0] ir; logic ov; logic [3:0] sel;} vec_t;
    beat_t q0[$], q1[$], q2[$];
    int p0 = 0, p2 = 0;
    logic ov0 = 1'b0, ov1 = 1'b0, ov2 = 1'b0;
    vec_t tbl[12];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    function automatic int gnt(input logic [15:0] v, input int p, input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            int i = mode != 0 ? k : (p + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction
    always @(negedge clk) begin
        int g;
        beat_t b;
        if (rst) begin
            chk("m0 rst in_ready", 64'(i0.in_ready), 0);
            p0 = 0; ov0 = 1'b0; q0.delete();
        end else begin
            g = gnt(i0.in_valid, p0, 0, 16);
            chk("m0 in_ready", 64'(i0.in_ready), ((!ov0 || i0.out_ready) && g >= 0) ? 64'(1) << g : 0);
            chk("m0 onehot", 64'($onehot0(i0.in_ready)), 1);
            chk("m0 out_valid", 64'(i0.out_valid), 64'(ov0));
            if (ov0 && i0.out_ready) begin
                b = q0.size() != 0 ? q0.pop_front() : '{-1, 0};
                chk("m0 sb sel", 64'(i0.out_sel), 64'(b.sel));
                chk("m0 sb data", 64'(i0.out_data), 64'(b.data));
            end
            if ((!ov0 || i0.out_ready) && g >= 0) begin
                q0.push_back('{g, 32'(i0.in_data[g*4 +: 4])});
                p0 = (g + 1) % 16; ov0 = 1'b1;
            end else if (i0.out_ready) ov0 = 1'b0;
        end
    end
    always @(negedge clk) begin
        int g;
        beat_t b;
        if (rst) begin
            chk("m1 rst in_ready", 64'(i1.in_ready), 0);
            ov1 = 1'b0; q1.delete();
        end else begin
            g = gnt(i1.in_valid, 0, 1, 16);
            chk("m1 in_ready", 64'(i1.in_ready), ((!ov1 || i1.out_ready) && g >= 0) ? 64'(1) << g : 0);
            chk("m1 out_valid", 64'(i1.out_valid), 64'(ov1));
            if (ov1 && i1.out_ready) begin
                b = q1.size() != 0 ? q1.pop_front() : '{-1, 0};
                chk("m1 sb sel", 64'(i1.out_sel), 64'(b.sel));
                chk("m1 sb data", 64'(i1.out_data), 64'(b.data));
            end
            if ((!ov1 || i1.out_ready) && g >= 0) begin
                q1.push_back('{g, 32'(i1.in_data[g*4 +: 4])});
                ov1 = 1'b1;
            end else if (i1.out_ready) ov1 = 1'b0;
        end
    end
    always @(negedge clk) begin
        int g;
        beat_t b;
        if (rst) begin
            chk("m2 rst in_ready", 64'(i2.in_ready), 0);
            p2 = 0; ov2 = 1'b0; q2.delete();
        end else begin
            g = gnt(16'(i2.in_valid), p2, 0, 5);
            chk("m2 in_ready", 64'(i2.in_ready), ((!ov2 || i2.out_ready) && g >= 0) ? 64'(1) << g : 0);
            chk("m2 out_valid", 64'(i2.out_valid), 64'(ov2));
            if (ov2 && i2.out_ready) begin
                b = q2.size() != 0 ? q2.pop_front() : '{-1, 0};
                chk("m2 sb sel", 64'(i2.out_sel), 64'(b.sel));
                chk("m2 sb data", 64'(i2.out_data), 64'(b.data));
            end
            if ((!ov2 || i2.out_ready) && g >= 0) begin
                q2.push_back('{g, i2.in_data[g*32 +: 32]});
                p2 = (g + 1) % 5; ov2 = 1'b1;
            end else if (i2.out_ready) ov2 = 1'b0;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic run(input int u, input vec_t t, input string nm);
        if (u == 0) begin i0.in_valid = t.v; i0.out_ready = t.rdy; end
        else begin i1.in_valid = t.v; i1.out_ready = t.rdy; end
        @(negedge clk);
        chk({nm, " in_ready"}, 64'(u == 0 ? i0.in_ready : i1.in_ready), 64'(t.ir));
        tick();
        chk({nm, " out_valid"}, 64'(u == 0 ? i0.out_valid : i1.out_valid), 64'(t.ov));
        chk({nm, " out_sel"}, 64'(u == 0 ? i0.out_sel : i1.out_sel), 64'(t.sel));
        chk({nm, " out_data"}, 64'(u == 0 ? i0.out_data : i1.out_data), 64'(t.sel));
    endtask
    initial begin
        tbl[0]  = '{16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'd0};
        tbl[1]  = '{16'hFFFF, 1'b1, 16'h0002, 1'b1, 4'd1};
        tbl[2]  = '{16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0};
        tbl[3]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0};
        tbl[4]  = '{16'h8000, 1'b0, 16'h8000, 1'b1, 4'd15};
        tbl[5]  = '{16'h8001, 1'b0, 16'h0000, 1'b1, 4'd15};
        tbl[6]  = '{16'h8001, 1'b1, 16'h0001, 1'b1, 4'd0};
        tbl[7]  = '{16'h8001, 1'b1, 16'h8000, 1'b1, 4'd15};
        tbl[8]  = '{16'h0005, 1'b1, 16'h0001, 1'b1, 4'd0};
        tbl[9]  = '{16'h0005, 1'b1, 16'h0004, 1'b1, 4'd2};
        tbl[10] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 4'd2};
        tbl[11] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2};
        for (int i = 0; i < 16; i++) begin
            i0.in_data[i*4 +: 4] = 4'(i);
            i1.in_data[i*4 +: 4] = 4'(i);
        end
        i2.in_data = '0;
        i0.in_valid = '0; i1.in_valid = '0; i2.in_valid = '0;
        i0.out_ready = 1'b1; i1.out_ready = 1'b1; i2.out_ready = 1'b1;
        tick();
        do_reset();
        chk("reset out_valid", 64'(i0.out_valid), 0);
        chk("reset out_sel", 64'(i0.out_sel), 0);
        chk("reset out_data", 64'(i0.out_data), 0);
        for (int r = 0; r < 12; r++) run(0, tbl[r], $sformatf("tbl%0d", r));
        run(0, '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5}, "load ch5");
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready during rst", 64'(i0.in_ready), 0);
        tick();
        rst = 1'b0;
        chk("mid rst out_valid", 64'(i0.out_valid), 0);
        chk("mid rst out_sel", 64'(i0.out_sel), 0);
        chk("mid rst out_data", 64'(i0.out_data), 0);
        run(0, '{16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'd0}, "first after rst");
        do_reset();
        for (int k = 0; k < 18; k++)
            run(0, '{16'hFFFF, 1'b1, 16'(1) << (k % 16), 1'b1, 4'(k % 16)}, $sformatf("rr%0d", k));
        run(0, '{16'h2000, 1'b1, 16'h2000, 1'b1, 4'd13}, "to ptr14");
        run(0, '{16'h0005, 1'b1, 16'h0001, 1'b1, 4'd0}, "wrap to 0");
        run(0, '{16'h0005, 1'b1, 16'h0004, 1'b1, 4'd2}, "skip to 2");
        run(0, '{16'h0080, 1'b1, 16'h0080, 1'b1, 4'd7}, "load ch7");
        for (int k = 0; k < 3; k++) run(0, '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd7}, "stall");
        run(0, '{16'hFFFF, 1'b1, 16'h0100, 1'b1, 4'd8}, "resume");
        for (int k = 0; k < 5; k++) run(1, '{16'h8010, 1'b1, 16'h0010, 1'b1, 4'd4}, "fixed ch4");
        run(1, '{16'h8000, 1'b1, 16'h8000, 1'b1, 4'd15}, "fixed ch15");
        for (int c = 0; c < 400; c++) begin
            i0.in_valid = 16'($urandom); i1.in_valid = 16'($urandom); i2.in_valid = 5'($urandom);
            i0.out_ready = $urandom_range(0, 3) != 0;
            i1.out_ready = $urandom_range(0, 3) != 0;
            i2.out_ready = $urandom_range(0, 2) != 0;
            i0.in_data = 64'({$urandom, $urandom});
            i1.in_data = 64'({$urandom, $urandom});
            for (int i = 0; i < 5; i++) i2.in_data[i*32 +: 32] = $urandom;
            tick();
        end
        i0.in_valid = '0; i1.in_valid = '0; i2.in_valid = '0;
        i0.out_ready = 1'b1; i1.out_ready = 1'b1; i2.out_ready = 1'b1;
        repeat (3) tick();
        chk("drain q0", 64'(q0.size()), 0);
        chk("drain q1", 64'(q1.size()), 0);
        chk("drain q2", 64'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
